// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_file_if
// Purpose  : EX-stage request/response bundle between the pipeline and csr_file.
// Revision : 1.0  initial release
// ============================================================================

interface csr_file_if #(
   parameter int XLEN = 32
);
   logic            valid;
   logic [XLEN-1:0] pc;
   logic [11:0]     csr_addr;
   logic [2:0]      csr_funct3;
   logic            csr_we;
   logic [XLEN-1:0] csr_wdata;
   logic            is_ecall;
   logic            is_mret;
   logic            instr_retire;
   logic [XLEN-1:0] csr_rdata;
   logic            trap_redirect;
   logic [XLEN-1:0] trap_target;

   modport master (
      output valid, pc, csr_addr, csr_funct3, csr_we, csr_wdata,
             is_ecall, is_mret, instr_retire,
      input  csr_rdata, trap_redirect, trap_target
   );

   modport slave (
      input  valid, pc, csr_addr, csr_funct3, csr_we, csr_wdata,
             is_ecall, is_mret, instr_retire,
      output csr_rdata, trap_redirect, trap_target
   );
endinterface

`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Purpose  : Machine-mode CSR file and trap sequencer (ECALL / MRET / illegal).
//            Optional 64-bit mcycle/minstret counters under CSR_COUNTERS_EN.
// Revision : 1.0  initial release
// ============================================================================

module csr_file #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [XLEN-1:0] HART_ID     = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   csr_file_if.slave   bus
);

   localparam logic [11:0] c_addr_mstatus  = 12'h300;
   localparam logic [11:0] c_addr_misa     = 12'h301;
   localparam logic [11:0] c_addr_mie      = 12'h304;
   localparam logic [11:0] c_addr_mtvec    = 12'h305;
   localparam logic [11:0] c_addr_mscratch = 12'h340;
   localparam logic [11:0] c_addr_mepc     = 12'h341;
   localparam logic [11:0] c_addr_mcause   = 12'h342;
   localparam logic [11:0] c_addr_mhartid  = 12'hF14;
`ifdef CSR_COUNTERS_EN
   localparam logic [11:0] c_addr_mcycle    = 12'hB00;
   localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
   localparam logic [11:0] c_addr_minstret  = 12'hB02;
   localparam logic [11:0] c_addr_minstreth = 12'hB82;
`endif

   localparam logic [XLEN-1:0] c_misa_value    = 32'h4000_0100;
   localparam logic [XLEN-1:0] c_cause_illegal = 32'd2;
   localparam logic [XLEN-1:0] c_cause_ecall   = 32'd11;
   localparam logic [2:0]      c_funct3_bad    = 3'b100;

   // Architectural state
   logic             r_mstatus_mie;
   logic             r_mstatus_mpie;
   logic [XLEN-1:0]  r_mie;
   logic [XLEN-1:2]  r_mtvec;
   logic [XLEN-1:0]  r_mscratch;
   logic [XLEN-1:2]  r_mepc;
   logic [XLEN-1:0]  r_mcause;
`ifdef CSR_COUNTERS_EN
   logic [63:0]      r_mcycle;
   logic [63:0]      r_minstret;
`endif

   logic [XLEN-1:0]  w_mstatus;
   logic [XLEN-1:0]  w_mtvec;
   logic [XLEN-1:0]  w_mepc;
   logic [XLEN-1:0]  w_old;
   logic [XLEN-1:0]  w_new;
   logic             w_impl;
   logic             w_ro;
   logic             w_req;
   logic             w_eff_write;
   logic             w_illegal;
   logic             w_ecall;
   logic             w_mret;
   logic             w_trap;
   logic             w_do_write;
   logic             w_unused;

   assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
   assign w_mtvec   = {r_mtvec, 2'b00};
   assign w_mepc    = {r_mepc, 2'b00};

   // Read mux: also classifies the address as implemented / read-only.
   always_comb begin
      w_old  = '0;
      w_impl = 1'b1;
      w_ro   = 1'b0;
      case (bus.csr_addr)
         c_addr_mstatus:   w_old = w_mstatus;
         c_addr_misa:      begin w_old = c_misa_value; w_ro = 1'b1; end
         c_addr_mie:       w_old = r_mie;
         c_addr_mtvec:     w_old = w_mtvec;
         c_addr_mscratch:  w_old = r_mscratch;
         c_addr_mepc:      w_old = w_mepc;
         c_addr_mcause:    w_old = r_mcause;
         c_addr_mhartid:   begin w_old = HART_ID; w_ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
         c_addr_mcycle:    w_old = r_mcycle[31:0];
         c_addr_mcycleh:   w_old = r_mcycle[63:32];
         c_addr_minstret:  w_old = r_minstret[31:0];
         c_addr_minstreth: w_old = r_minstret[63:32];
`endif
         default:          w_impl = 1'b0;
      endcase
   end

   always_comb begin
      w_new = w_old;
      case (bus.csr_funct3[1:0])
         2'b01:   w_new = bus.csr_wdata;
         2'b10:   w_new = w_old | bus.csr_wdata;
         2'b11:   w_new = w_old & ~bus.csr_wdata;
         default: w_new = w_old;
      endcase
   end

   // Set/clear with a zero mask is a pure read and must not fault on read-only CSRs.
   assign w_eff_write = (bus.csr_funct3[1:0] == 2'b01) |
                        (bus.csr_funct3[1] & (|bus.csr_wdata));
   assign w_req       = bus.valid & bus.csr_we;
   assign w_illegal   = w_req & (~w_impl | (w_eff_write & w_ro) |
                                 (bus.csr_funct3 == c_funct3_bad));
   assign w_ecall     = bus.valid & bus.is_ecall & ~w_illegal;
   assign w_mret      = bus.valid & bus.is_mret & ~w_illegal & ~bus.is_ecall;
   assign w_trap      = w_illegal | w_ecall;
   assign w_do_write  = w_req & w_eff_write & ~w_trap & ~w_mret;

   assign bus.csr_rdata     = rst_n ? w_old : '0;
   assign bus.trap_redirect = rst_n & (w_trap | w_mret);

   always_comb begin
      bus.trap_target = '0;
      if (rst_n) begin
         if (w_trap)
            bus.trap_target = w_mtvec;
         else if (w_mret)
            bus.trap_target = w_mepc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= '0;
         r_mtvec        <= MTVEC_RESET[XLEN-1:2];
         r_mscratch     <= '0;
         r_mepc         <= '0;
         r_mcause       <= '0;
      end else if (w_trap) begin
         r_mepc         <= bus.pc[XLEN-1:2];
         r_mcause       <= w_illegal ? c_cause_illegal : c_cause_ecall;
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mie  <= 1'b0;
      end else if (w_mret) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
      end else if (w_do_write) begin
         case (bus.csr_addr)
            c_addr_mstatus:  begin
               r_mstatus_mie  <= w_new[3];
               r_mstatus_mpie <= w_new[7];
            end
            c_addr_mie:      r_mie      <= w_new;
            c_addr_mtvec:    r_mtvec    <= w_new[XLEN-1:2];
            c_addr_mscratch: r_mscratch <= w_new;
            c_addr_mepc:     r_mepc     <= w_new[XLEN-1:2];
            c_addr_mcause:   r_mcause   <= w_new;
            default:         ;
         endcase
      end
   end

`ifdef CSR_COUNTERS_EN
   logic w_cyc_wr_lo;
   logic w_cyc_wr_hi;
   logic w_ret_wr_lo;
   logic w_ret_wr_hi;

   assign w_cyc_wr_lo = w_do_write & (bus.csr_addr == c_addr_mcycle);
   assign w_cyc_wr_hi = w_do_write & (bus.csr_addr == c_addr_mcycleh);
   assign w_ret_wr_lo = w_do_write & (bus.csr_addr == c_addr_minstret);
   assign w_ret_wr_hi = w_do_write & (bus.csr_addr == c_addr_minstreth);

   // A write to either half cancels that cycle's increment for the full counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         if (w_cyc_wr_lo | w_cyc_wr_hi) begin
            if (w_cyc_wr_lo) r_mcycle[31:0]  <= w_new;
            if (w_cyc_wr_hi) r_mcycle[63:32] <= w_new;
         end else begin
            r_mcycle <= r_mcycle + 64'd1;
         end

         if (w_ret_wr_lo | w_ret_wr_hi) begin
            if (w_ret_wr_lo) r_minstret[31:0]  <= w_new;
            if (w_ret_wr_hi) r_minstret[63:32] <= w_new;
         end else if (bus.instr_retire) begin
            r_minstret <= r_minstret + 64'd1;
         end
      end
   end

   assign w_unused = &{1'b0, bus.pc[1:0]};
`else
   assign w_unused = &{1'b0, bus.pc[1:0], bus.instr_retire};
`endif

endmodule

`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Purpose  : Directed vector table, hand sequences and randomized run against
//            a mask-table reference model of the machine CSRs.
// Revision : 1.0  initial release
// ============================================================================

module tb_csr_file;

   localparam logic [31:0] P_MTVEC = 32'h0000_0203;
   localparam logic [31:0] P_HART  = 32'd5;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [11:0] addr;
      logic [2:0]  f3;
      logic        we;
      logic [31:0] wdata;
      logic        ecall;
      logic        mret;
      logic        retire;
      logic [31:0] e_rdata;
      logic        e_redir;
      logic [31:0] e_tgt;
      bit          no_rd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   csr_file_if #(.XLEN(32)) bus ();

   csr_file #(
      .XLEN        (32),
      .MTVEC_RESET (P_MTVEC),
      .HART_ID     (P_HART)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model: each CSR is a stored value with a write mask, a set of
   // bits that always read as one, and a read-only flag.
   logic [31:0] m_val  [int];
   logic [31:0] m_mask [int];
   logic [31:0] m_fix  [int];
   bit          m_ro   [int];
   logic [63:0] m_cyc;
   logic [63:0] m_ret;

   function automatic void m_def(int a, logic [31:0] v, logic [31:0] mask,
                                 logic [31:0] fix, bit ro);
      m_val[a] = v; m_mask[a] = mask; m_fix[a] = fix; m_ro[a] = ro;
   endfunction

   function automatic void model_reset();
      m_val.delete(); m_mask.delete(); m_fix.delete(); m_ro.delete();
      m_def('h300, 32'h0, 32'h0000_0088, 32'h0000_1800, 1'b0);
      m_def('h301, 32'h4000_0100, 32'h0, 32'h0, 1'b1);
      m_def('h304, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      m_def('h305, P_MTVEC & ~32'h3, ~32'h3, 32'h0, 1'b0);
      m_def('h340, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      m_def('h341, 32'h0, ~32'h3, 32'h0, 1'b0);
      m_def('h342, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      m_def('hF14, P_HART, 32'h0, 32'h0, 1'b1);
`ifdef CSR_COUNTERS_EN
      m_def('hB00, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      m_def('hB80, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      m_def('hB02, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
      m_def('hB82, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
`endif
      m_cyc = 64'd0;
      m_ret = 64'd0;
   endfunction

   function automatic logic [31:0] m_read(int a);
`ifdef CSR_COUNTERS_EN
      if (a == 'hB00) return m_cyc[31:0];
      if (a == 'hB80) return m_cyc[63:32];
      if (a == 'hB02) return m_ret[31:0];
      if (a == 'hB82) return m_ret[63:32];
`endif
      if (!m_val.exists(a)) return 32'h0;
      if (m_ro[a]) return m_val[a];
      return (m_val[a] & m_mask[a]) | m_fix[a];
   endfunction

   task automatic m_step(input vec_t vi, output vec_t vo);
      int          a;
      logic [31:0] old, nv, st;
      bit          req, eff, ill, ec, mr, wr, impl;
      logic [63:0] cn, rn;
      vo   = vi;
      a    = int'(vi.addr);
      impl = m_val.exists(a);
      old  = m_read(a);
      req  = vi.valid && vi.we;
      case (vi.f3[1:0])
         2'd1:    nv = vi.wdata;
         2'd2:    nv = old | vi.wdata;
         2'd3:    nv = old & ~vi.wdata;
         default: nv = old;
      endcase
      eff = (vi.f3[1:0] == 2'd1) || (vi.f3[1:0] >= 2'd2 && vi.wdata != 0);
      ill = req && (!impl || (eff && m_ro[a]) || vi.f3 == 3'b100);
      ec  = vi.valid && vi.ecall && !ill;
      mr  = vi.valid && vi.mret && !ill && !ec;
      wr  = req && eff && !ill && !ec && !mr;
      vo.e_rdata = old;
      vo.e_redir = ill || ec || mr;
      vo.e_tgt   = (ill || ec) ? m_read('h305) : (mr ? m_read('h341) : 32'h0);
      cn = m_cyc + 64'd1;
      rn = m_ret + (vi.retire ? 64'd1 : 64'd0);
      st = m_val['h300];
      if (ill || ec) begin
         m_val['h341] = vi.pc & ~32'h3;
         m_val['h342] = ill ? 32'd2 : 32'd11;
         m_val['h300] = st[3] ? 32'h80 : 32'h0;
      end else if (mr) begin
         m_val['h300] = 32'h80 | (st[7] ? 32'h8 : 32'h0);
      end else if (wr) begin
         m_val[a] = nv & m_mask[a];
         if (a == 'hB00) cn = {m_cyc[63:32], nv};
         if (a == 'hB80) cn = {nv, m_cyc[31:0]};
         if (a == 'hB02) rn = {m_ret[63:32], nv};
         if (a == 'hB82) rn = {nv, m_ret[31:0]};
      end
      m_cyc = cn;
      m_ret = rn;
   endtask

   function automatic vec_t mk(logic v, logic [31:0] pc, logic [11:0] a,
                               logic [2:0] f, logic we, logic [31:0] wd,
                               logic ec, logic mr, logic [31:0] er,
                               logic ed, logic [31:0] et);
      vec_t r;
      r.valid = v; r.pc = pc; r.addr = a; r.f3 = f; r.we = we; r.wdata = wd;
      r.ecall = ec; r.mret = mr; r.retire = 1'b0;
      r.e_rdata = er; r.e_redir = ed; r.e_tgt = et; r.no_rd = 1'b0;
      return r;
   endfunction

   function automatic vec_t rd(logic [11:0] a, logic [31:0] er);
      return mk(1, 32'h0, a, 3'b010, 0, 32'h0, 0, 0, er, 0, 32'h0);
   endfunction

   task automatic drive(input vec_t v);
      bus.valid        = v.valid;
      bus.pc           = v.pc;
      bus.csr_addr     = v.addr;
      bus.csr_funct3   = v.f3;
      bus.csr_we       = v.we;
      bus.csr_wdata    = v.wdata;
      bus.is_ecall     = v.ecall;
      bus.is_mret      = v.mret;
      bus.instr_retire = v.retire;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: actual=%08h required=%08h", nm, act, exp);
      end
   endtask

   // Called at a negedge: drive, sample mid-low-phase, then advance one cycle.
   task automatic apply(input string tag, input vec_t v);
      drive(v);
      #1;
      if (!v.no_rd) check({tag, " rdata"}, bus.csr_rdata, v.e_rdata);
      check({tag, " redirect"}, {31'd0, bus.trap_redirect}, {31'd0, v.e_redir});
      check({tag, " target"}, bus.trap_target, v.e_tgt);
      @(posedge clk);
      @(negedge clk);
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      logic [11:0] addrs [15];
      addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h000, 12'h7C0,
                12'h302};

      // Reset: outputs held at zero even with a live trap request.
      drive(mk(1, 32'h10, 12'h301, 3'b001, 1, 32'h1, 1, 0, 0, 0, 0));
      @(negedge clk);
      #1;
      check("reset rdata", bus.csr_rdata, 32'h0);
      check("reset redirect", {31'd0, bus.trap_redirect}, 32'h0);
      check("reset target", bus.trap_target, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      //            valid pc           addr     f3      we wdata         ec mr rdata         redir target
      tbl.push_back(rd(12'h305, 32'h0000_0200));
      tbl.push_back(rd(12'h301, 32'h4000_0100));
      tbl.push_back(mk(1, 32'h0,    12'h340, 3'b001, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 32'h0));
      tbl.push_back(mk(1, 32'h0,    12'h340, 3'b010, 1, 32'h0000_0010, 0, 0, 32'hDEAD_BEEF, 0, 32'h0));
      tbl.push_back(mk(1, 32'h0,    12'h340, 3'b011, 1, 32'hF000_0000, 0, 0, 32'hDEAD_BEFF, 0, 32'h0));
      tbl.push_back(mk(1, 32'h0,    12'h340, 3'b010, 1, 32'h0,         0, 0, 32'h0EAD_BEFF, 0, 32'h0));
      tbl.push_back(mk(1, 32'h0,    12'h305, 3'b001, 1, 32'h0000_0100, 0, 0, 32'h0000_0200, 0, 32'h0));
      tbl.push_back(mk(1, 32'h0,    12'h300, 3'b010, 1, 32'h0000_0008, 0, 0, 32'h0000_1800, 0, 32'h0));
      tbl.push_back(mk(1, 32'h2004, 12'h000, 3'b000, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100));
      tbl.push_back(rd(12'h341, 32'h0000_2004));
      tbl.push_back(rd(12'h342, 32'd11));
      tbl.push_back(rd(12'h300, 32'h0000_1880));
      tbl.push_back(mk(1, 32'h3000, 12'h302, 3'b000, 0, 32'h0,         0, 1, 32'h0,         1, 32'h2004));
      tbl.push_back(rd(12'h300, 32'h0000_1888));
      tbl.push_back(mk(1, 32'h40,   12'hF14, 3'b001, 1, 32'h7,         0, 0, P_HART,        1, 32'h100));
      tbl.push_back(rd(12'h342, 32'd2));
      tbl.push_back(rd(12'h341, 32'h40));
      tbl.push_back(mk(1, 32'h48,   12'hF14, 3'b010, 1, 32'h0,         0, 0, P_HART,        0, 32'h0));
      tbl.push_back(rd(12'h300, 32'h0000_1880));
      tbl.push_back(mk(1, 32'h3000, 12'h340, 3'b001, 1, 32'h1234,      1, 0, 32'h0EAD_BEFF, 1, 32'h100));
      tbl.push_back(rd(12'h340, 32'h0EAD_BEFF));
      tbl.push_back(mk(0, 32'h5000, 12'h340, 3'b001, 1, 32'h55,        1, 1, 32'h0EAD_BEFF, 0, 32'h0));
      tbl.push_back(rd(12'h340, 32'h0EAD_BEFF));
      tbl.push_back(rd(12'h341, 32'h3000));
      tbl.push_back(mk(1, 32'h44,   12'h340, 3'b100, 1, 32'h99,        0, 0, 32'h0EAD_BEFF, 1, 32'h100));
      tbl.push_back(rd(12'h342, 32'd2));
      tbl.push_back(mk(1, 32'h0,    12'h341, 3'b001, 1, 32'h1237,      0, 0, 32'h44,        0, 32'h0));
      tbl.push_back(rd(12'h341, 32'h1234));
      tbl.push_back(mk(1, 32'h0,    12'h302, 3'b000, 0, 32'h0,         0, 1, 32'h0,         1, 32'h1234));
      tbl.push_back(rd(12'h300, 32'h0000_1880));
      tbl.push_back(rd(12'h340, 32'h0EAD_BEFF));

      for (int i = 0; i < tbl.size(); i++)
         apply($sformatf("vec%0d", i), tbl[i]);

      // Asynchronous reset mid-cycle discards an in-flight ECALL.
      drive(mk(1, 32'h6000, 12'h340, 3'b000, 0, 32'h0, 1, 0, 0, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst rdata", bus.csr_rdata, 32'h0);
      check("async rst redirect", {31'd0, bus.trap_redirect}, 32'h0);
      check("async rst target", bus.trap_target, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      apply("post-rst mscratch", rd(12'h340, 32'h0));
      apply("post-rst mepc", rd(12'h341, 32'h0));
      apply("post-rst mcause", rd(12'h342, 32'h0));
      apply("post-rst mstatus", rd(12'h300, 32'h0000_1800));
      apply("post-rst mtvec", rd(12'h305, 32'h0000_0200));

`ifdef CSR_COUNTERS_EN
      v = mk(1, 32'h0, 12'hB00, 3'b001, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
      v.no_rd = 1'b1;
      apply("mcycle wr lo", v);
      apply("mcycle wr hi", mk(1, 32'h0, 12'hB80, 3'b001, 1, 32'h0, 0, 0, 32'h0, 0, 32'h0));
      apply("mcycle run0", rd(12'h340, 32'h0));
      apply("mcycle run1", rd(12'h340, 32'h0));
      apply("mcycle run2", rd(12'h340, 32'h0));
      apply("mcycle lo", rd(12'hB00, 32'h1));
      apply("mcycle hi", rd(12'hB80, 32'h1));
      apply("minstret wr lo", mk(1, 32'h0, 12'hB02, 3'b001, 1, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, 32'h0));
      v = rd(12'hB82, 32'h0);
      v.retire = 1'b1;
      apply("minstret retire", v);
      apply("minstret hi", rd(12'hB82, 32'h1));
      apply("minstret lo", rd(12'hB02, 32'h0));
`else
      apply("no-counter trap", mk(1, 32'h88, 12'hB00, 3'b010, 1, 32'h0, 0, 0, 32'h0, 1, 32'h200));
      apply("no-counter mcause", rd(12'h342, 32'd2));
      apply("no-counter mepc", rd(12'h341, 32'h88));
`endif

      // Randomized run against the reference model.
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 400; i++) begin
         vec_t vi, vo;
         vi = mk(($urandom % 8) != 0, $urandom, addrs[$urandom_range(0, 14)],
                 3'($urandom % 8), 1'($urandom % 2),
                 (($urandom % 4) == 0) ? 32'h0 : $urandom,
                 ($urandom % 16) == 0, ($urandom % 16) == 0, 0, 0, 0);
         vi.retire = 1'($urandom % 2);
         m_step(vi, vo);
         apply($sformatf("rnd%0d a=%03h f=%0d", i, vi.addr, vi.f3), vo);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file and trap sequencer, sitting directly downstream of the decode control logic.
- Consumes csr_we, csr_to_reg, is_ecall, is_mret and funct3 from decode (staged to EX by the pipeline), and holds all architectural CSR state.
- Returns read data for write-back and produces the PC redirect for ECALL, MRET and illegal CSR access.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] are ignored.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- valid  input  1  instruction in this stage is live; when 0, all other request inputs are ignored
- pc  input  32  PC of the instruction in this stage
- csr_addr  input  12  instruction bits [31:20]
- csr_funct3  input  3  instruction funct3
- csr_we  input  1  CSR access requested
- csr_wdata  input  32  rs1 value or zero-extended zimm, muxed upstream
- is_ecall  input  1  ECALL in this stage
- is_mret  input  1  MRET in this stage
- instr_retire  input  1  one instruction retired this cycle
- csr_rdata  output  32  combinational old value of csr_addr
- trap_redirect  output  1  combinational; flush and redirect this cycle
- trap_target  output  32  combinational redirect PC

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE = bit 3, MPIE = bit 7; MPP [12:11] reads 2'b11; all other bits read 0 and writes to them are dropped.
  - misa 0x301: read-only, 32'h4000_0100.
  - mie 0x304: full 32-bit read/write.
  - mtvec 0x305: bits [1:0] forced 0 (direct mode).
  - mscratch 0x340: full 32-bit read/write.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342: full 32-bit read/write.
  - mhartid 0xF14: read-only, HART_ID.
- Read: csr_rdata = current value of csr_addr, with zero latency. Unimplemented addresses read 0.
- New-value computation, selected by funct3[1:0]:
  - 01 (W): wdata.
  - 10 (S): old | wdata.
  - 11 (C): old & ~wdata.
  - 00: no write.
- funct3[2] does not affect the write.
- Effective write: valid & csr_we & (W, or S/C with wdata != 0). The register commits on the next clk rising edge.
- Illegal access, when valid & csr_we:
  - unimplemented address; or
  - effective write to a read-only CSR (misa, mhartid); or
  - funct3 == 100.
- On an illegal access the write is suppressed and a trap is taken with mcause = 2.
- Trap entry (ECALL: mcause = 11; illegal: mcause = 2):
  - Same cycle: trap_redirect = 1, trap_target = mtvec.
  - At the edge: mepc <= {pc[31:2], 2'b00}; mcause <= cause; MPIE <= MIE; MIE <= 0.
- MRET:
  - Same cycle: trap_redirect = 1, trap_target = mepc.
  - At the edge: MIE <= MPIE; MPIE <= 1.
- Priority within one cycle: illegal > ECALL > MRET > CSR write. A trap suppresses any CSR write in the same cycle.
- valid = 0: trap_redirect = 0, no state change (counters excepted).
- Idle outputs: trap_redirect = 0 and trap_target = 0 whenever no redirect is active.
- Reset (asynchronous, any cycle):
  - mstatus MIE = MPIE = 0; mtvec = {MTVEC_RESET[31:2], 2'b00}; mepc, mcause, mscratch, mie = 0; counters = 0.
  - Outputs are forced to 0 while rst_n is low. An in-flight trap is discarded.

Optional Feature:
CSR_COUNTERS_EN
- Defined:
  - 64-bit mcycle (low 0xB00, high 0xB80) increments every cycle.
  - 64-bit minstret (low 0xB02, high 0xB82) increments when instr_retire = 1.
  - Both are read/write. A CSR write to either half wins over that cycle's increment for the whole 64-bit counter; the other half keeps its pre-increment value.
  - Carry from low to high happens when the low half wraps from 32'hFFFF_FFFF to 0.
- Undefined: these four addresses are unimplemented and accessing them raises the illegal trap.

Test Plan:
- Reset, then read 0x305 and 0x301 → csr_rdata = MTVEC_RESET & ~3, then 32'h4000_0100; trap_redirect = 0.
- CSRRW 0x340 with wdata = 32'hDEAD_BEEF; next cycle CSRRS with wdata = 0x10; then CSRRC with wdata = 32'hF000_0000 → reads return DEAD_BEEF, then DEAD_BEFF, then 0EAD_BEFF.
- Set mtvec = 0x100 and MIE = 1, then ECALL at pc = 0x2004:
  - same cycle: trap_redirect = 1, target = 0x100;
  - after the edge: mepc = 0x2004, mcause = 11, mstatus = 0x1880.
  - Then MRET → target = 0x2004; mstatus = 0x1888.
- CSRRW to 0xF14 at pc = 0x40 → redirect to mtvec, mcause = 2, mepc = 0x40, mhartid unchanged. Same test with CSRRS wdata = 0 → no trap, reads HART_ID.
- Same-cycle ECALL and csr_we to mscratch; also valid = 0 with is_ecall = 1 → the first traps with mscratch unchanged; the second gives no redirect and no state change.
- CSR_COUNTERS_EN: write mcycle low = 32'hFFFF_FFFE, high = 0; run 3 cycles → {high, low} = {1, 1}. Without the macro, a read of 0xB00 traps with mcause = 2.
